// File: rtl/rasterint_multi.sv
// Multi-channel raster interrupt controller: NCHAN programmable raster lines with sticky
// pending flags, lowest-index arbitration and a fixed-length INT pulse with retry gap.
module rasterint_multi #(
  parameter int         NCHAN    = 4,
  parameter int         LINE_W   = 9,
  parameter logic [8:0] HC_TRIG  = 9'd0,
  parameter int         INT_LEN  = 32,
  parameter logic [7:0] REG_BASE = 8'h40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] vc,
  input  logic [8:0]        hc,
  input  logic [7:0]        zxuno_addr,
  input  logic              zxuno_regrd,
  input  logic              zxuno_regwr,
  input  logic [7:0]        din,
  input  logic              cpu_intack,
  output logic [7:0]        dout,
  output logic              oe,
  output logic              int_n,
  output logic              vretraceint_disable,
  output logic              rasterint_in_progress
);

  localparam int               HI_W        = LINE_W - 8;
  localparam int               CNT_W       = $clog2(INT_LEN);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(INT_LEN - 1);
  localparam logic [7:0]       GLOBAL_ADDR = REG_BASE + 8'(2 * NCHAN);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       chan_q, chan_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             int_n_q;
  logic             vrd_q;

  logic [NCHAN-1:0] pend_vec;
  logic [7:0]       rd_lo   [NCHAN];
  logic [7:0]       rd_ctrl [NCHAN];
  logic             ack_clr;
  logic             global_wr;
  logic [2:0]       lowest;

  // Only the accepted acknowledge (inside the low pulse) clears the serviced flag.
  assign ack_clr   = (state_q == S_ASSERT) && cpu_intack;
  assign global_wr = zxuno_regwr && (zxuno_addr == GLOBAL_ADDR);

  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
    localparam logic [7:0] LO_ADDR   = REG_BASE + 8'(2 * gi);
    localparam logic [7:0] CTRL_ADDR = REG_BASE + 8'(2 * gi + 1);

    logic [LINE_W-1:0] line_q;
    logic              en_q;
    logic              pend_q;
    logic              wr_lo, wr_ctrl, match, clr;

    assign wr_lo   = zxuno_regwr && (zxuno_addr == LO_ADDR);
    assign wr_ctrl = zxuno_regwr && (zxuno_addr == CTRL_ADDR);
    assign match   = en_q && (vc == line_q) && (hc == HC_TRIG);
    assign clr     = (wr_ctrl && (din[7] || !din[6])) || (ack_clr && (chan_q == 3'(gi)));

    always_ff @(posedge clk) begin
      if (rst) begin
        line_q <= '1;
        en_q   <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        if (wr_lo) line_q[7:0] <= din;
        if (wr_ctrl) begin
          line_q[LINE_W-1:8] <= din[HI_W-1:0];
          en_q               <= din[6];
        end
        // A match always beats any clear landing on the same edge.
        if (match)    pend_q <= 1'b1;
        else if (clr) pend_q <= 1'b0;
      end
    end

    assign pend_vec[gi] = pend_q;
    assign rd_lo[gi]    = line_q[7:0];
    assign rd_ctrl[gi]  = {pend_q, en_q, 2'b00, 4'(line_q[LINE_W-1:8])};
  end

  always_comb begin
    lowest = 3'd0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (pend_vec[i]) lowest = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (|pend_vec) begin
          state_d = S_ASSERT;
          chan_d  = lowest;
          cnt_d   = CNT_LOAD;
        end
      end
      S_ASSERT: begin
        if (cpu_intack) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      chan_q  <= 3'd0;
      cnt_q   <= '0;
      int_n_q <= 1'b1;
      vrd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      int_n_q <= (state_d != S_ASSERT);
      if (global_wr) vrd_q <= din[0];
    end
  end

  always_comb begin
    dout = 8'hFF;
    oe   = 1'b0;
    if (zxuno_regrd) begin
      if (zxuno_addr == GLOBAL_ADDR) begin
        dout = {(state_q == S_ASSERT), chan_q, 3'b000, vrd_q};
        oe   = 1'b1;
      end
      for (int i = 0; i < NCHAN; i++) begin
        if (zxuno_addr == REG_BASE + 8'(2 * i)) begin
          dout = rd_lo[i];
          oe   = 1'b1;
        end
        if (zxuno_addr == REG_BASE + 8'(2 * i + 1)) begin
          dout = rd_ctrl[i];
          oe   = 1'b1;
        end
      end
    end
  end

  // CTRL bits [5:4] carry no state; drained here so they do not dangle.
  logic unused_din;
  assign unused_din = ^din[5:4];

  assign int_n                 = int_n_q;
  assign vretraceint_disable   = vrd_q;
  assign rasterint_in_progress = (state_q == S_ASSERT);

endmodule

// File: tb/tb_rasterint_multi.sv
// Bench for rasterint_multi: directed scenarios with fixed expectations, then a randomized
// run compared cycle by cycle with a behavioural model of the register file and INT sequencing.
module tb_rasterint_multi;

  localparam int NCHAN   = 4;
  localparam int LINE_W  = 9;
  localparam int INT_LEN = 32;
  localparam int RB      = 'h40;
  localparam int GADDR   = RB + 2 * NCHAN;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [LINE_W-1:0] vc = '0;
  logic [8:0]        hc = 9'd5;
  logic [7:0]        zxuno_addr = 8'h00;
  logic              zxuno_regrd = 1'b0;
  logic              zxuno_regwr = 1'b0;
  logic [7:0]        din = 8'h00;
  logic              cpu_intack = 1'b0;
  logic [7:0]        dout;
  logic              oe;
  logic              int_n;
  logic              vretraceint_disable;
  logic              rasterint_in_progress;

  int checks = 0;
  int failures = 0;

  rasterint_multi #(
    .NCHAN(NCHAN), .LINE_W(LINE_W), .HC_TRIG(9'd0), .INT_LEN(INT_LEN), .REG_BASE(8'h40)
  ) dut (
    .clk(clk), .rst(rst), .vc(vc), .hc(hc),
    .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
    .din(din), .cpu_intack(cpu_intack), .dout(dout), .oe(oe), .int_n(int_n),
    .vretraceint_disable(vretraceint_disable), .rasterint_in_progress(rasterint_in_progress)
  );

  always #5 clk = ~clk;

  // Behavioural model: registers plus a pulse "age" counting cycles since the INT began.
  logic [LINE_W-1:0] m_line [NCHAN];
  bit m_en [NCHAN];
  bit m_pend [NCHAN];
  bit m_old [NCHAN];
  bit m_vrd, m_busy, m_any, m_ack;
  int m_age, m_chan, m_low;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCHAN; i++) begin
        m_line[i] = '1; m_en[i] = 0; m_pend[i] = 0;
      end
      m_vrd = 0; m_busy = 0; m_age = 0; m_chan = 0;
    end else begin
      m_any = 0; m_low = 0;
      for (int i = NCHAN - 1; i >= 0; i--) begin
        m_old[i] = m_pend[i];
        if (m_pend[i]) begin m_any = 1; m_low = i; end
      end
      m_ack = m_busy && (m_age < INT_LEN) && cpu_intack;
      for (int i = 0; i < NCHAN; i++) begin
        bit hit;
        hit = m_en[i] && (vc == m_line[i]) && (hc == 9'd0);
        if (zxuno_regwr && zxuno_addr == 8'(RB + 2 * i)) m_line[i][7:0] = din;
        if (zxuno_regwr && zxuno_addr == 8'(RB + 2 * i + 1)) begin
          m_line[i][8] = din[0];
          m_en[i] = din[6];
          if (din[7] || !din[6]) m_pend[i] = 0;
        end
        if (m_ack && m_chan == i) m_pend[i] = 0;
        if (hit) m_pend[i] = 1;
      end
      if (zxuno_regwr && zxuno_addr == 8'(GADDR)) m_vrd = din[0];
      if (!m_busy) begin
        if (m_any) begin m_busy = 1; m_age = 0; m_chan = m_low; end
      end else if (m_age < INT_LEN) begin
        if (cpu_intack) m_busy = 0; else m_age++;
      end else if (m_age == 2 * INT_LEN - 1) begin
        m_busy = 0;
      end else begin
        m_age++;
      end
    end
  end

  function automatic logic [8:0] exp_rd(input logic [7:0] a, input logic rd);
    logic [8:0] r;
    r = {1'b0, 8'hFF};
    if (rd) begin
      if (a == 8'(GADDR))
        r = {1'b1, (m_busy && m_age < INT_LEN), 3'(m_chan), 3'b000, m_vrd};
      for (int i = 0; i < NCHAN; i++) begin
        if (a == 8'(RB + 2 * i))     r = {1'b1, m_line[i][7:0]};
        if (a == 8'(RB + 2 * i + 1)) r = {1'b1, m_pend[i], m_en[i], 5'b00000, m_line[i][8]};
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    zxuno_addr = a; din = d; zxuno_regwr = 1'b1;
    step();
    zxuno_regwr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic o);
    zxuno_addr = a; zxuno_regrd = 1'b1;
    #1;
    d = dout; o = oe;
    zxuno_regrd = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; cpu_intack = 1'b0; zxuno_regwr = 1'b0; hc = 9'd5; vc = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic match_once(input logic [LINE_W-1:0] line);
    vc = line; hc = 9'd0;
    step();
    hc = 9'd5; vc = '0;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic o;
    apply_reset();
    rd(8'h41, d, o); checks++;
    if (d !== 8'h01 || o !== 1'b1) begin failures++; $display("FAIL reset_ctrl0 got=%h/%b want=01/1", d, o); end
    rd(8'h40, d, o); checks++;
    if (d !== 8'hFF || o !== 1'b1) begin failures++; $display("FAIL reset_linelo0 got=%h/%b want=ff/1", d, o); end
    rd(8'h48, d, o); checks++;
    if (d !== 8'h00 || o !== 1'b1) begin failures++; $display("FAIL reset_global got=%h/%b want=00/1", d, o); end
    rd(8'h3F, d, o); checks++;
    if (d !== 8'hFF || o !== 1'b0) begin failures++; $display("FAIL unmapped_read got=%h/%b want=ff/0", d, o); end
    checks++;
    if (int_n !== 1'b1 || vretraceint_disable !== 1'b0) begin
      failures++; $display("FAIL reset_outputs int_n=%b vrd=%b want=1/0", int_n, vretraceint_disable);
    end
  endtask

  task automatic test_basic_ack();
    logic [7:0] d; logic o;
    apply_reset();
    wr(8'h40, 8'h00); wr(8'h41, 8'h41);
    match_once(9'h100);
    rd(8'h41, d, o); checks++;
    if (d !== 8'hC1 || int_n !== 1'b1) begin failures++; $display("FAIL pending_set ctrl0=%h int_n=%b want=c1/1", d, int_n); end
    step(); checks++;
    if (int_n !== 1'b0 || rasterint_in_progress !== 1'b1) begin
      failures++; $display("FAIL int_assert int_n=%b rip=%b want=0/1", int_n, rasterint_in_progress);
    end
    cpu_intack = 1'b1; step(); cpu_intack = 1'b0;
    rd(8'h41, d, o); checks++;
    if (int_n !== 1'b1 || d !== 8'h41) begin failures++; $display("FAIL ack_release int_n=%b ctrl0=%h want=1/41", int_n, d); end
  endtask

  task automatic test_no_ack();
    logic [7:0] d; logic o; int lo, hi, w;
    apply_reset();
    wr(8'h40, 8'h00); wr(8'h41, 8'h41);
    match_once(9'h100);
    w = 0;
    while (int_n !== 1'b0 && w < 4) begin step(); w++; end
    lo = 0;
    while (int_n === 1'b0 && lo < 200) begin lo++; step(); end
    checks++;
    if (lo != INT_LEN) begin failures++; $display("FAIL pulse_width low=%0d want=%0d", lo, INT_LEN); end
    hi = 0;
    while (int_n === 1'b1 && hi < 200) begin hi++; step(); end
    checks++;
    if (hi < INT_LEN || hi > INT_LEN + 1) begin failures++; $display("FAIL gap_width high=%0d want=%0d..%0d", hi, INT_LEN, INT_LEN + 1); end
    rd(8'h48, d, o); checks++;
    if (d !== 8'h80 || int_n !== 1'b0) begin failures++; $display("FAIL retry_global global=%h int_n=%b want=80/0", d, int_n); end
  endtask

  task automatic test_priority();
    logic [7:0] d; logic o;
    apply_reset();
    wr(8'h42, 8'h55); wr(8'h43, 8'h40); wr(8'h46, 8'h55); wr(8'h47, 8'h40);
    match_once(9'h055);
    step();
    rd(8'h48, d, o); checks++;
    if (int_n !== 1'b0 || d !== 8'h90) begin failures++; $display("FAIL prio_first int_n=%b global=%h want=0/90", int_n, d); end
    cpu_intack = 1'b1; step(); cpu_intack = 1'b0;
    rd(8'h47, d, o); checks++;
    if (int_n !== 1'b1 || d !== 8'hC0) begin failures++; $display("FAIL prio_ack int_n=%b ctrl3=%h want=1/c0", int_n, d); end
    step();
    rd(8'h48, d, o); checks++;
    if (int_n !== 1'b0 || d !== 8'hB0) begin failures++; $display("FAIL prio_second int_n=%b global=%h want=0/b0", int_n, d); end
  endtask

  task automatic test_w1c_race();
    logic [7:0] d; logic o; int bad;
    apply_reset();
    wr(8'h44, 8'hAA); wr(8'h45, 8'h40);
    vc = 9'h0AA; hc = 9'd0;
    wr(8'h45, 8'hC0);
    hc = 9'd5; vc = '0;
    rd(8'h45, d, o); checks++;
    if (d !== 8'hC0) begin failures++; $display("FAIL w1c_race ctrl2=%h want=c0", d); end
    wr(8'h45, 8'h00);
    rd(8'h45, d, o); checks++;
    if (d !== 8'h00 || int_n !== 1'b0) begin failures++; $display("FAIL disable_clear ctrl2=%h int_n=%b want=00/0", d, int_n); end
    cpu_intack = 1'b1; step(); cpu_intack = 1'b0;
    match_once(9'h0AA);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (int_n !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL disabled_no_int low_cycles=%0d want=0", bad); end
  endtask

  task automatic test_reset_midpulse();
    logic [7:0] d; logic o;
    apply_reset();
    wr(8'h40, 8'h00); wr(8'h41, 8'h41);
    match_once(9'h100);
    step(); step(); step();
    rst = 1'b1; step(); checks++;
    if (int_n !== 1'b1 || rasterint_in_progress !== 1'b0) begin
      failures++; $display("FAIL reset_midpulse int_n=%b rip=%b want=1/0", int_n, rasterint_in_progress);
    end
    rst = 1'b0;
    rd(8'h41, d, o); checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL reset_midpulse_ctrl ctrl0=%h want=01", d); end
    wr(8'h48, 8'h01);
    rd(8'h48, d, o); checks++;
    if (vretraceint_disable !== 1'b1 || d !== 8'h01) begin
      failures++; $display("FAIL vretrace_disable vrd=%b global=%h want=1/01", vretraceint_disable, d);
    end
  endtask

  task automatic test_random();
    logic [LINE_W-1:0] lines [4];
    logic [8:0] e;
    int rbad, obad;
    lines[0] = 9'h010; lines[1] = 9'h011; lines[2] = 9'h110; lines[3] = 9'h1FF;
    apply_reset();
    rbad = 0; obad = 0;
    for (int c = 0; c < 1500; c++) begin
      vc = lines[$urandom_range(0, 3)];
      hc = ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
      cpu_intack = ($urandom_range(0, 5) == 0);
      zxuno_regwr = ($urandom_range(0, 3) == 0);
      zxuno_addr = 8'($urandom_range(RB - 1, GADDR + 1));
      din = 8'($urandom);
      if (zxuno_regwr && zxuno_addr < 8'(GADDR) && zxuno_addr[0] == 1'b0)
        din = lines[$urandom_range(0, 3)][7:0];
      zxuno_regrd = $urandom_range(0, 1) == 1;
      #1;
      e = exp_rd(zxuno_addr, zxuno_regrd); checks++;
      if ({oe, dout} !== e) begin
        failures++; rbad++;
        if (rbad < 5) $display("FAIL rand_read cyc=%0d addr=%h got=%b/%h want=%b/%h", c, zxuno_addr, oe, dout, e[8], e[7:0]);
      end
      step();
      checks++;
      if (int_n !== !(m_busy && m_age < INT_LEN) || rasterint_in_progress !== (m_busy && m_age < INT_LEN)
          || vretraceint_disable !== m_vrd) begin
        failures++; obad++;
        if (obad < 5) $display("FAIL rand_outputs cyc=%0d int_n=%b rip=%b vrd=%b want_int_n=%b want_vrd=%b",
                               c, int_n, rasterint_in_progress, vretraceint_disable, !(m_busy && m_age < INT_LEN), m_vrd);
      end
    end
    zxuno_regwr = 1'b0; zxuno_regrd = 1'b0; cpu_intack = 1'b0;
    $display("random run: %0d cycles, read errors=%0d output errors=%0d", 1500, rbad, obad);
  endtask

  initial begin
    test_reset();
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
    test_basic_ack();
    $display("test_basic_ack done checks=%0d failures=%0d", checks, failures);
    test_no_ack();
    $display("test_no_ack done checks=%0d failures=%0d", checks, failures);
    test_priority();
    $display("test_priority done checks=%0d failures=%0d", checks, failures);
    test_w1c_race();
    $display("test_w1c_race done checks=%0d failures=%0d", checks, failures);
    test_reset_midpulse();
    $display("test_reset_midpulse done checks=%0d failures=%0d", checks, failures);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
